// File: rtl/sync_fifo_pkg.sv
// Shared default sizing for the synchronous FIFO and its storage.
package sync_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 4;
  localparam int unsigned DEFAULT_MEM_SIZE   = 16;

endpackage : sync_fifo_pkg

// File: rtl/fifo_mem.sv
// FIFO storage: one write port, one registered read port.
module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned MEM_SIZE   = DEFAULT_MEM_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] MEM [MEM_SIZE];

  // Storage array is never cleared; only accepted writes change it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      MEM[wr_addr] <= wr_data;
    end
  end

  // Read register loads on accepted reads and otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= MEM[rd_addr];
    end
  end

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock FIFO: wrap-bit pointers, combinational flags, registered read data.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned MEM_SIZE   = DEFAULT_MEM_SIZE
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  FULL,
  input  logic                  R_INC,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  EMPTY
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  if (MEM_SIZE != (1 << ADDR_WIDTH)) begin : g_bad_size
    $error("sync_fifo: MEM_SIZE must equal 2**ADDR_WIDTH");
  end

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [ADDR_WIDTH-1:0] Wr_ADDR;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  wr_accept_c;
  logic                  rd_accept_c;

  // Flags and request qualification; reset cycles accept nothing.
  always_comb begin
    Wr_ADDR     = wr_ptr[ADDR_WIDTH-1:0];
    rd_addr     = rd_ptr[ADDR_WIDTH-1:0];
    EMPTY       = (wr_ptr == rd_ptr);
    FULL        = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                  (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    wr_accept_c = W_INC && !FULL && !RST;
    rd_accept_c = R_INC && !EMPTY && !RST;
  end

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_accept_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_SIZE   (MEM_SIZE)
  ) FIFO_MEMORY (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (wr_accept_c),
    .wr_addr (Wr_ADDR),
    .wr_data (WR_DATA),
    .rd_en   (rd_accept_c),
    .rd_addr (rd_addr),
    .rd_data (RD_DATA)
  );

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       W_INC = 1'b0;
  logic       R_INC = 1'b0;
  logic [7:0] WR_DATA = 8'h00;
  logic       FULL;
  logic       EMPTY;
  logic [7:0] RD_DATA;

  sync_fifo dut (
    .CLK     (CLK),
    .RST     (RST),
    .W_INC   (W_INC),
    .WR_DATA (WR_DATA),
    .FULL    (FULL),
    .R_INC   (R_INC),
    .RD_DATA (RD_DATA),
    .EMPTY   (EMPTY)
  );

  always #5 CLK = ~CLK;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  int         wr_total = 0;
  bit         active = 0;
  bit         rd_chk = 0;
  bit         exp_empty = 1;
  bit         exp_full = 0;
  logic [3:0] exp_waddr = '0;
  logic [7:0] hold_val = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
  endtask

  // One clock of stimulus; expected read data goes to the scoreboard queue.
  task automatic cycle(input bit w, input bit r, input bit rst, input logic [7:0] d);
    bit rd_ok;
    bit wr_ok;
    logic [7:0] head;
    W_INC = w; R_INC = r; RST = rst; WR_DATA = d;
    rd_ok = !rst && r && (model_q.size() > 0);
    wr_ok = !rst && w && (model_q.size() < 16);
    if (rst) exp_q.push_back(8'h00);
    else if (rd_ok) exp_q.push_back(model_q[0]);
    @(posedge CLK);
    if (rst) begin
      model_q.delete();
      wr_total = 0;
    end else begin
      if (rd_ok) head = model_q.pop_front();
      if (wr_ok) begin
        model_q.push_back(d);
        wr_total++;
      end
    end
    #1;
    rd_chk    = rst || rd_ok;
    exp_empty = (model_q.size() == 0);
    exp_full  = (model_q.size() == 16);
    exp_waddr = 4'(wr_total);
    active    = 1;
  endtask

  // Monitor: flags every cycle, read data popped on each read, held otherwise.
  always @(negedge CLK) begin
    if (active) begin
      chk("empty", 32'(EMPTY), 32'(exp_empty));
      chk("full", 32'(FULL), 32'(exp_full));
      chk("wr_addr", 32'(dut.Wr_ADDR), 32'(exp_waddr));
      if (rd_chk) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard: read seen with no expected data at %0t", $time);
        end else begin
          hold_val = exp_q.pop_front();
          chk("rd_data", 32'(RD_DATA), 32'(hold_val));
        end
      end else begin
        chk("rd_hold", 32'(RD_DATA), 32'(hold_val));
      end
    end
  end

  logic [7:0] pkt [10] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D,
                           8'h8D, 8'h65, 8'h12, 8'h01, 8'h0D};

  initial begin
    // Reset
    cycle(0, 0, 1, 8'h00);
    cycle(0, 0, 0, 8'h00);
    // Packet in, packet out
    foreach (pkt[i]) cycle(1, 0, 0, pkt[i]);
    for (int i = 0; i < 10; i++) cycle(0, 1, 0, 8'h00);
    // Underflow: RD_DATA holds 0x0D
    cycle(0, 1, 0, 8'h00);
    cycle(0, 1, 0, 8'h00);
    // Fill, overflow attempt, drain
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 8'(i));
    cycle(1, 0, 0, 8'hFF);
    cycle(1, 1, 0, 8'hEE);
    cycle(0, 1, 0, 8'h00);
    for (int i = 0; i < 15; i++) cycle(0, 1, 0, 8'h00);
    cycle(1, 1, 0, 8'h77);
    cycle(0, 1, 0, 8'h00);
    // Steady occupancy of 3 across pointer wraps
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'($urandom));
    for (int i = 0; i < 40; i++) cycle(1, 1, 0, 8'($urandom));
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'h00);
    // Mid-operation reset
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 8'(8'h50 + i));
    cycle(1, 1, 1, 8'h99);
    cycle(1, 0, 0, 8'hAA);
    cycle(0, 1, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);
    // Randomized traffic, write-biased then read-biased, rare resets
    for (int i = 0; i < 300; i++)
      cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 99) == 0), 8'($urandom));
    for (int i = 0; i < 300; i++)
      cycle(($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 99) == 0), 8'($urandom));
    cycle(0, 0, 0, 8'h00);
    @(negedge CLK);
    #1;
    active = 0;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sync_fifo
